decode_stage: RTL and testbench

- ID stage of the five-stage core, and the ID/EX pipeline register.
- Takes the fetched instruction and drives the register-file read addresses. Resolves operands from the register file or by bypass from EX, MEM and WB.
- Generates the immediate, detects load-use hazards, and registers the decoded bundle for EX.
- Handles stall and flush bubbles.

---
 rtl/rv32_pkg.sv | 26 ++
 rtl/decode_stage_imm_gen.sv | 30 +++
 rtl/decode_stage.sv | 176 +++++++++++++++++
 tb/tb_decode_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I definitions for the decode stage.
//   - XLEN default datapath width
//   - NOP_INSN, the instruction word carried by pipeline bubbles (addi x0,x0,0)
//   - base opcode constants plus a helper that recognises them
package rv32_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_LUI)    || (op == OP_AUIPC) || (op == OP_JAL)   ||
           (op == OP_JALR)   || (op == OP_BRANCH) || (op == OP_LOAD) ||
           (op == OP_STORE)  || (op == OP_IMM)   || (op == OP_REG);
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate generator.
//   insn : instruction word
//   imm  : sign-extended immediate (I/S/B/U/J by opcode); 0 for R-type
//          and unrecognised opcodes
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] insn,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (insn[6:0])
      OP_LOAD, OP_IMM, OP_JALR:
        imm = {{20{insn[31]}}, insn[31:20]};
      OP_STORE:
        imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      OP_BRANCH:
        imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {insn[31:12], 12'b0};
      OP_JAL:
        imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage and ID/EX pipeline register of a five-stage core.
// Drives register-file read addresses, resolves operands (bypass from
// EX/MEM/WB or register file), generates the immediate, detects hazards and
// registers the decoded bundle for EX. Stall, flush and if_valid=0 load bubbles.
//
// Ports:
//   clock, reset (sync, active-high)
//   if_valid/if_pc/if_insn         fetched instruction
//   rf_addr_rs1/2, rf_data_rs1/2   register-file read port
//   ex_*/mem_*/wb_*                downstream destination info and results
//   flush                          kill the instruction in ID
//   stall_if                       hold PC and IF/ID this cycle
//   id_*                           registered bundle for EX
//
// Build option: DECODE_FORWARDING_EN
//   defined   : EX/MEM bypass; only a load in EX feeding a used rs stalls.
//   undefined : no EX/MEM bypass; any used rs matching a writing EX or MEM rd
//               stalls. WB bypass is present in both builds because the
//               register file returns the old value on its write edge.
module decode_stage #(
  parameter int          XLEN     = rv32_pkg::XLEN,
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter logic [31:0] NOP_INSN = rv32_pkg::NOP_INSN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_pc,
  input  logic [31:0]     if_insn,
  output logic [4:0]      rf_addr_rs1,
  output logic [4:0]      rf_addr_rs2,
  input  logic [XLEN-1:0] rf_data_rs1,
  input  logic [XLEN-1:0] rf_data_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_we,
  input  logic            ex_is_load,
  input  logic [XLEN-1:0] ex_data,
  input  logic [4:0]      mem_rd,
  input  logic            mem_reg_we,
  input  logic [XLEN-1:0] mem_data,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_we,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            stall_if,
  output logic            id_valid,
  output logic [31:0]     id_pc,
  output logic [31:0]     id_insn,
  output logic [XLEN-1:0] id_rs1_val,
  output logic [XLEN-1:0] id_rs2_val,
  output logic [31:0]     id_imm,
  output logic [4:0]      id_rd,
  output logic            id_reg_we
);

  import rv32_pkg::*;

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic            uses_rs1, uses_rs2;
  logic            hazard, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [31:0]     imm;

  logic            id_valid_q,   id_valid_d;
  logic [31:0]     id_pc_q,      id_pc_d;
  logic [31:0]     id_insn_q,    id_insn_d;
  logic [XLEN-1:0] id_rs1_val_q, id_rs1_val_d;
  logic [XLEN-1:0] id_rs2_val_q, id_rs2_val_d;
  logic [31:0]     id_imm_q,     id_imm_d;
  logic [4:0]      id_rd_q,      id_rd_d;
  logic            id_reg_we_q,  id_reg_we_d;

  assign opcode      = if_insn[6:0];
  assign rs1         = if_insn[19:15];
  assign rs2         = if_insn[24:20];
  assign rd          = if_insn[11:7];
  assign rf_addr_rs1 = rs1;
  assign rf_addr_rs2 = rs2;

  assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  imm_gen u_imm_gen (
    .insn (if_insn),
    .imm  (imm)
  );

`ifdef DECODE_FORWARDING_EN
  // Only a load result is not yet available in EX; everything else bypasses.
  assign hazard = ex_is_load && ex_reg_we && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
`else
  assign hazard = (ex_reg_we && (ex_rd != 5'd0) &&
                   ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)))) ||
                  (mem_reg_we && (mem_rd != 5'd0) &&
                   ((uses_rs1 && (mem_rd == rs1)) || (uses_rs2 && (mem_rd == rs2))));

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_is_load, ex_data, mem_data};
`endif

  // Flush discards the wrong-path instruction, so it never holds fetch.
  assign stall_if = !reset && !flush && if_valid && hazard;
  assign accept   = if_valid && !flush && !hazard;

  // Later assignments override earlier ones, giving the bypass priority
  // x0 > EX > MEM > WB > register file.
  always_comb begin
    rs1_val = rf_data_rs1;
    rs2_val = rf_data_rs2;
    if (wb_reg_we && (wb_rd == rs1)) rs1_val = wb_data;
    if (wb_reg_we && (wb_rd == rs2)) rs2_val = wb_data;
`ifdef DECODE_FORWARDING_EN
    if (mem_reg_we && (mem_rd == rs1)) rs1_val = mem_data;
    if (mem_reg_we && (mem_rd == rs2)) rs2_val = mem_data;
    if (ex_reg_we && !ex_is_load && (ex_rd == rs1)) rs1_val = ex_data;
    if (ex_reg_we && !ex_is_load && (ex_rd == rs2)) rs2_val = ex_data;
`endif
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  always_comb begin
    id_valid_d   = 1'b0;
    id_pc_d      = if_pc;
    id_insn_d    = NOP_INSN;
    id_rs1_val_d = '0;
    id_rs2_val_d = '0;
    id_imm_d     = '0;
    id_rd_d      = '0;
    id_reg_we_d  = 1'b0;
    if (accept) begin
      id_valid_d   = 1'b1;
      id_insn_d    = if_insn;
      id_rs1_val_d = rs1_val;
      id_rs2_val_d = rs2_val;
      id_imm_d     = imm;
      id_rd_d      = rd;
      id_reg_we_d  = is_known_op(opcode) && (opcode != OP_STORE) &&
                     (opcode != OP_BRANCH) && (rd != 5'd0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      id_valid_q   <= 1'b0;
      id_pc_q      <= RESET_PC;
      id_insn_q    <= NOP_INSN;
      id_rs1_val_q <= '0;
      id_rs2_val_q <= '0;
      id_imm_q     <= '0;
      id_rd_q      <= '0;
      id_reg_we_q  <= 1'b0;
    end else begin
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_insn_q    <= id_insn_d;
      id_rs1_val_q <= id_rs1_val_d;
      id_rs2_val_q <= id_rs2_val_d;
      id_imm_q     <= id_imm_d;
      id_rd_q      <= id_rd_d;
      id_reg_we_q  <= id_reg_we_d;
    end
  end

  assign id_valid   = id_valid_q;
  assign id_pc      = id_pc_q;
  assign id_insn    = id_insn_q;
  assign id_rs1_val = id_rs1_val_q;
  assign id_rs2_val = id_rs2_val_q;
  assign id_imm     = id_imm_q;
  assign id_rd      = id_rd_q;
  assign id_reg_we  = id_reg_we_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

`ifdef DECODE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [31:0] T_NOP   = 32'h0000_0013;
  localparam logic [31:0] T_RSTPC = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc, if_insn;
  logic [4:0]  rf_addr_rs1, rf_addr_rs2;
  logic [31:0] rf_data_rs1, rf_data_rs2;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_reg_we, ex_is_load, mem_reg_we, wb_reg_we;
  logic [31:0] ex_data, mem_data, wb_data;
  logic        flush, stall_if;
  logic        id_valid, id_reg_we;
  logic [31:0] id_pc, id_insn, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rd;

  decode_stage dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc), .if_insn(if_insn),
    .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2),
    .rf_data_rs1(rf_data_rs1), .rf_data_rs2(rf_data_rs2),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load), .ex_data(ex_data),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_data(mem_data),
    .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_data(wb_data),
    .flush(flush), .stall_if(stall_if),
    .id_valid(id_valid), .id_pc(id_pc), .id_insn(id_insn),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_rd(id_rd), .id_reg_we(id_reg_we)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic        e_stall, e_valid, e_we;
  logic [31:0] e_pc, e_insn, e_r1, e_r2, e_imm;
  logic [4:0]  e_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic [31:0] sgn;
    sgn = w[31] ? 32'hFFFF_FFFF : 32'h0;
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: return (sgn << 12) | (w >> 20);
      7'b0100011: return (sgn << 12) | ((w >> 25) << 5) | ((w >> 7) & 32'd31);
      7'b1100011: return (sgn << 12) | (((w >> 7) & 32'd1) << 11) |
                         (((w >> 25) & 32'd63) << 5) | (((w >> 8) & 32'd15) << 1);
      7'b0110111, 7'b0010111: return w & 32'hFFFF_F000;
      7'b1101111: return (sgn << 20) | (w & 32'h000F_F000) |
                         (((w >> 20) & 32'd1) << 11) | (((w >> 21) & 32'd1023) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 32'h0;
    if (FWD && ex_reg_we && ex_rd == r && !ex_is_load) return ex_data;
    if (FWD && mem_reg_we && mem_rd == r) return mem_data;
    if (wb_reg_we && wb_rd == r) return wb_data;
    return rf;
  endfunction

  // Reference: what ID should do with the current inputs.
  task automatic model();
    logic [6:0] op;
    logic [4:0] r1, r2;
    bit u1, u2, haz, known, ex_hit, mem_hit;
    op = if_insn[6:0];
    r1 = if_insn[19:15];
    r2 = if_insn[24:20];
    u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    known = op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                       7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    ex_hit  = ex_reg_we && ex_rd != 0 && ((u1 && ex_rd == r1) || (u2 && ex_rd == r2));
    mem_hit = mem_reg_we && mem_rd != 0 && ((u1 && mem_rd == r1) || (u2 && mem_rd == r2));
    haz = FWD ? (ex_hit && ex_is_load) : (ex_hit || mem_hit);
    e_stall = if_valid && !flush && haz;
    e_valid = if_valid && !flush && !haz;
    e_pc    = if_pc;
    e_insn  = e_valid ? if_insn : T_NOP;
    e_rd    = if_insn[11:7];
    e_we    = e_valid && known && op != 7'b0100011 && op != 7'b1100011 && e_rd != 0;
    e_r1    = ref_operand(r1, rf_data_rs1);
    e_r2    = ref_operand(r2, rf_data_rs2);
    e_imm   = ref_imm(if_insn);
  endtask

  task automatic step(input string tag);
    model();
    #1;
    chk({tag, "/stall_if"}, 32'(stall_if), 32'(e_stall));
    chk({tag, "/rf_addr_rs1"}, 32'(rf_addr_rs1), 32'(if_insn[19:15]));
    chk({tag, "/rf_addr_rs2"}, 32'(rf_addr_rs2), 32'(if_insn[24:20]));
    @(posedge clock);
    #1;
    chk({tag, "/id_valid"}, 32'(id_valid), 32'(e_valid));
    chk({tag, "/id_pc"}, id_pc, e_pc);
    chk({tag, "/id_insn"}, id_insn, e_insn);
    chk({tag, "/id_reg_we"}, 32'(id_reg_we), 32'(e_we));
    if (e_valid) begin
      chk({tag, "/id_rs1_val"}, id_rs1_val, e_r1);
      chk({tag, "/id_rs2_val"}, id_rs2_val, e_r2);
      chk({tag, "/id_imm"}, id_imm, e_imm);
      chk({tag, "/id_rd"}, 32'(id_rd), 32'(e_rd));
    end
  endtask

  task automatic idle();
    if_valid = 0; if_pc = 32'h0100_0000; if_insn = T_NOP;
    rf_data_rs1 = 0; rf_data_rs2 = 0;
    ex_rd = 0; ex_reg_we = 0; ex_is_load = 0; ex_data = 0;
    mem_rd = 0; mem_reg_we = 0; mem_data = 0;
    wb_rd = 0; wb_reg_we = 0; wb_data = 0;
    flush = 0;
  endtask

  function automatic logic [31:0] enc_r(input int rd, input int a, input int b);
    return {7'd0, 5'(b), 5'(a), 3'd0, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input int rd, input int a, input int imm);
    return {12'(imm), 5'(a), 3'd0, 5'(rd), op};
  endfunction

  logic [6:0] ops [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011,
                           7'b0001111};

  initial begin
    idle();
    // Reset beats a concurrent flush and a hazardous fetch.
    reset = 1; flush = 1; if_valid = 1; if_pc = 32'h0000_0040;
    if_insn = enc_r(6, 5, 1); ex_rd = 5; ex_reg_we = 1; ex_is_load = 1;
    #2;
    chk("reset/stall_if", 32'(stall_if), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 0;
    idle();
    chk("reset/id_valid", 32'(id_valid), 32'd0);
    chk("reset/id_reg_we", 32'(id_reg_we), 32'd0);
    chk("reset/id_rd", 32'(id_rd), 32'd0);
    chk("reset/id_pc", id_pc, T_RSTPC);
    chk("reset/id_insn", id_insn, T_NOP);
    chk("reset/id_rs1_val", id_rs1_val, 32'd0);
    chk("reset/id_rs2_val", id_rs2_val, 32'd0);
    chk("reset/id_imm", id_imm, 32'd0);
    #1;
    chk("release/stall_if", 32'(stall_if), 32'd0);

    idle(); if_pc = 32'h0100_0010;
    step("invalid_fetch");

    idle(); if_valid = 1; if_pc = 32'h0100_0000; if_insn = enc_i(7'b0010011, 5, 0, 7);
    step("addi_x5");
    idle(); if_valid = 1; if_pc = 32'h0100_0004; if_insn = enc_r(6, 5, 5);
    ex_rd = 5; ex_reg_we = 1; ex_data = 7; rf_data_rs1 = 32'h55; rf_data_rs2 = 32'h55;
    step("add_fwd_ex");

    // Load-use: load in EX, then in MEM, then in WB.
    idle(); if_valid = 1; if_pc = 32'h0100_0008; if_insn = enc_r(6, 5, 1);
    ex_rd = 5; ex_reg_we = 1; ex_is_load = 1; rf_data_rs2 = 32'h11;
    step("loaduse_ex");
    ex_rd = 0; ex_reg_we = 0; ex_is_load = 0;
    mem_rd = 5; mem_reg_we = 1; mem_data = 32'hDEAD_BEEF;
    step("loaduse_mem");
    mem_rd = 0; mem_reg_we = 0;
    wb_rd = 5; wb_reg_we = 1; wb_data = 32'hDEAD_BEEF;
    step("loaduse_wb");

    idle(); if_valid = 1; if_pc = 32'h0100_0020; if_insn = enc_i(7'b0010011, 8, 7, 0);
    wb_rd = 7; wb_reg_we = 1; wb_data = 32'h1234_5678; rf_data_rs1 = 0;
    step("wb_same_edge");

    idle(); if_valid = 1; if_pc = 32'h0100_0024; if_insn = enc_r(6, 5, 1);
    ex_rd = 5; ex_reg_we = 1; ex_is_load = 1; flush = 1;
    step("loaduse_flush");

    idle(); if_valid = 1; if_pc = 32'h0100_0028; if_insn = enc_r(0, 1, 2);
    rf_data_rs1 = 3; rf_data_rs2 = 4;
    step("add_x0_dest");
    idle(); if_valid = 1; if_pc = 32'h0100_002C; if_insn = enc_r(9, 0, 0);
    ex_rd = 0; ex_reg_we = 1; ex_data = 5; rf_data_rs1 = 5; rf_data_rs2 = 5;
    step("read_x0");

    idle(); if_valid = 1;
    if_insn = 32'hFE31_2E23; step("store_neg");
    if_insn = 32'hFE20_8EE3; step("branch_neg");
    if_insn = 32'h8000_006F; step("jal_neg");
    if_insn = 32'h8000_02B7; step("lui_high");
    if_insn = 32'hFFF0_8093; step("addi_neg");
    if_insn = 32'h0000_0073; step("unknown_op");

    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0]   = ops[$urandom_range(0, 10)];
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      if_insn = w;
      if_valid = ($urandom_range(0, 7) != 0);
      if_pc = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      rf_data_rs1 = $urandom; rf_data_rs2 = $urandom;
      ex_rd = 5'($urandom_range(0, 3)); ex_reg_we = 1'($urandom);
      ex_is_load = 1'($urandom); ex_data = $urandom;
      mem_rd = 5'($urandom_range(0, 3)); mem_reg_we = 1'($urandom); mem_data = $urandom;
      wb_rd = 5'($urandom_range(0, 3)); wb_reg_we = 1'($urandom); wb_data = $urandom;
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
